// File: rtl/fetch_queue.sv
// Sequential instruction fetch with a 1-cycle synchronous imem and a small FIFO
// toward the execute core; redirect flushes the queue and restarts at the target.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        ins_valid,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    input  logic        ins_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [31:0] NOP = 32'h00000013;

    logic [31:0]   fetch_pc;
    logic          inflight;
    logic [31:0]   inflight_pc;
    logic [31:0]   pc_mem  [DEPTH];
    logic [31:0]   ins_mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW:0]   occ;
    logic          enq;
    logic          deq;

    // Occupancy counts the outstanding read so the queue can never overflow;
    // a same-cycle dequeue is deliberately not credited.
    assign occ       = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign imem_req  = !rst && (redirect || (occ < DEPTH_W));
    assign imem_addr = redirect ? {redirect_pc[31:2], 2'b00} : fetch_pc;

    assign ins_valid = !rst && (count != '0);
    assign ins       = ins_valid ? ins_mem[rd_ptr] : NOP;
    assign ins_pc    = ins_valid ? pc_mem[rd_ptr]  : 32'h00000000;

    assign enq = inflight && !redirect;
    assign deq = ins_valid && ins_ready && !redirect;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h00000000;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                fetch_pc    <= imem_addr + 32'd4;
                inflight_pc <= imem_addr;
            end
            if (enq)
                wr_ptr <= wr_ptr + 1'b1;
            if (redirect) begin
                count  <= '0;
                rd_ptr <= wr_ptr;
            end else begin
                if (deq)
                    rd_ptr <= rd_ptr + 1'b1;
                if (enq && !deq)
                    count <= count + 1'b1;
                else if (deq && !enq)
                    count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && enq) begin
            pc_mem[wr_ptr]  <= inflight_pc;
            ins_mem[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: stimulus pushes the expected PC stream into a
// scoreboard queue and a negedge monitor checks every consumed instruction.
module tb_fetch_queue;
    localparam logic [31:0] KEY = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        ins_valid;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        ins_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h00000100)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .ins_valid(ins_valid), .ins(ins), .ins_pc(ins_pc), .ins_ready(ins_ready),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    // Instruction memory: one-cycle latency, word = address ^ KEY
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_addr ^ KEY;
        else          imem_rdata <= 32'hDEADBEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_stream(input logic [31:0] start);
        exp_q.delete();
        for (int k = 0; k < 64; k++) exp_q.push_back(start + 32'(4 * k));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ins_valid && ins_ready && !redirect) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_consume", ins_pc, 32'hFFFFFFFF);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    chk("sb_pc", ins_pc, e);
                    chk("sb_ins", ins, e ^ KEY);
                end
            end else if (!ins_valid) begin
                chk("empty_ins", ins, 32'h00000013);
                chk("empty_pc", ins_pc, 32'h0);
            end
        end
    end

    initial begin
        rst = 1'b1; ins_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        #1;
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_valid", {31'b0, ins_valid}, 32'h0);
        chk("rst_ins", ins, 32'h00000013);
        chk("rst_pc", ins_pc, 32'h0);

        // reset release and streaming
        load_stream(32'h100);
        rst = 1'b0; ins_ready = 1'b1;
        #1;
        chk("c0_req", {31'b0, imem_req}, 32'h1);
        chk("c0_addr", imem_addr, 32'h100);
        step(); #1;
        chk("c1_valid", {31'b0, ins_valid}, 32'h0);
        chk("c1_addr", imem_addr, 32'h104);
        step(); #1;
        chk("c2_valid", {31'b0, ins_valid}, 32'h1);
        chk("c2_pc", ins_pc, 32'h100);
        repeat (5) step();

        // backpressure
        step(); ins_ready = 1'b0;
        repeat (9) step();
        #1;
        chk("stall_req", {31'b0, imem_req}, 32'h0);
        chk("stall_valid", {31'b0, ins_valid}, 32'h1);
        chk("stall_pc", ins_pc, 32'h118);
        step(); ins_ready = 1'b1; #1;
        chk("release_req", {31'b0, imem_req}, 32'h0);
        step(); #1;
        chk("resume_req", {31'b0, imem_req}, 32'h1);
        chk("resume_addr", imem_addr, 32'h128);
        repeat (2) step();

        // redirect mid-stream with ready=1 and a response in flight
        step();
        load_stream(32'h2000);
        redirect = 1'b1; redirect_pc = 32'h2002; #1;
        chk("redir_req", {31'b0, imem_req}, 32'h1);
        chk("redir_addr", imem_addr, 32'h2000);
        step(); redirect = 1'b0; #1;
        chk("redir_t1_valid", {31'b0, ins_valid}, 32'h0);
        step(); #1;
        chk("redir_t2_valid", {31'b0, ins_valid}, 32'h1);
        chk("redir_t2_pc", ins_pc, 32'h2000);
        repeat (4) step();

        // address wrap
        step();
        load_stream(32'hFFFFFFF8);
        redirect = 1'b1; redirect_pc = 32'hFFFFFFF8; #1;
        chk("wrap_addr", imem_addr, 32'hFFFFFFF8);
        step(); redirect = 1'b0;
        step(); #1;
        chk("wrap_pc", ins_pc, 32'hFFFFFFF8);
        repeat (5) step();

        // back-to-back redirects: only the second survives
        step();
        exp_q.delete();
        redirect = 1'b1; redirect_pc = 32'h3000;
        step();
        load_stream(32'h4004);
        redirect_pc = 32'h4004; #1;
        chk("b2b_addr", imem_addr, 32'h4004);
        step(); redirect = 1'b0; #1;
        chk("b2b_t1_valid", {31'b0, ins_valid}, 32'h0);
        step(); #1;
        chk("b2b_t2_pc", ins_pc, 32'h4004);
        repeat (3) step();

        // fill, then reset with a read in flight
        step(); ins_ready = 1'b0;
        repeat (2) step();
        step();
        rst = 1'b1;
        load_stream(32'h100);
        #1;
        chk("mid_rst_req", {31'b0, imem_req}, 32'h0);
        chk("mid_rst_valid", {31'b0, ins_valid}, 32'h0);
        chk("mid_rst_ins", ins, 32'h00000013);
        step(); rst = 1'b0; ins_ready = 1'b1; #1;
        chk("post_rst_valid", {31'b0, ins_valid}, 32'h0);
        chk("post_rst_addr", imem_addr, 32'h100);
        chk("post_rst_req", {31'b0, imem_req}, 32'h1);
        step(); #1;
        chk("post_rst_t1_valid", {31'b0, ins_valid}, 32'h0);
        step(); #1;
        chk("post_rst_t2_pc", ins_pc, 32'h100);
        repeat (4) step();
        step(); ins_ready = 1'b0;
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
